// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data memory between CPU and debug port using
// fixed issue/response transactions, CPU priority and a debug starvation bound.
module dmem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, ISSUE_C, RESP_C, ISSUE_D, RESP_D} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
    logic          we_q, we_d, wr_q, wr_d, cpu_ack_q, cpu_ack_d, dbg_ack_q, dbg_ack_d;
    logic          idle, cpu_ok, dbg_ok, cpu_win, dbg_win;

    // a requester in its ack cycle is ignored so one request is never granted twice
    always_comb begin
        idle        = state_q == IDLE;
        cpu_ok      = cpu_req & ~cpu_ack_q;
        dbg_ok      = dbg_req & ~dbg_ack_q;
        dbg_win     = idle & dbg_ok & ((starve_q >= LIM) | ~cpu_ok);
        cpu_win     = idle & cpu_ok & ~dbg_win;
        state_d     = IDLE;
        case (state_q)
            IDLE:    state_d = dbg_win ? ISSUE_D : cpu_win ? ISSUE_C : IDLE;
            ISSUE_C: state_d = RESP_C;
            ISSUE_D: state_d = RESP_D;
            default: state_d = IDLE;
        endcase
        addr_d      = dbg_win ? dbg_addr : cpu_win ? cpu_addr : addr_q;
        wdata_d     = dbg_win ? dbg_wdata : cpu_win ? cpu_wdata : wdata_q;
        we_d        = (dbg_win & dbg_we) | (cpu_win & cpu_we);
        wr_d        = (dbg_win | cpu_win) ? we_d : wr_q;
        starve_d    = dbg_win ? '0 : (cpu_win & dbg_req & (starve_q < LIM)) ? starve_q + 1'b1 : starve_q;
        cpu_ack_d   = state_q == RESP_C;
        dbg_ack_d   = state_q == RESP_D;
        cpu_rdata_d = (cpu_ack_d & ~wr_q) ? mem_rdata : cpu_rdata_q;
        dbg_rdata_d = (dbg_ack_d & ~wr_q) ? mem_rdata : dbg_rdata_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wr_q        <= wr_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of arbitration, latency, starvation and reset.
module tb_dmem_port_arbiter;
    logic        clock = 1'b0;
    logic        resetn;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, cpu_ack, dbg_ack, cpu_stall, mem_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dbg_addr, dbg_wdata, dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:15];
    int          n_checks = 0;
    int          n_fail = 0;

    dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(8)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // synchronous memory: read data one cycle after the address
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        mem_rdata = '0;
        resetn = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4; cpu_wdata = 32'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8; dbg_wdata = 32'h0;
        step();
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", dbg_rdata, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd1);
        resetn = 1'b1;
        step();
        chk("first_grant_cpu", mem_addr, 32'h4);
        chk("first_grant_rd", {31'd0, mem_we}, 32'd0);
        step();
        step();
        chk("first_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        chk("first_cpu_rdata", cpu_rdata, 32'h1000_0001);
        chk("first_stall_low", {31'd0, cpu_stall}, 32'd0);
        chk("first_dbg_wait", {31'd0, dbg_ack}, 32'd0);
        cpu_req = 1'b0;
        step();
        chk("first_dbg_issue", mem_addr, 32'h8);
        step();
        step();
        chk("first_dbg_ack", {31'd0, dbg_ack}, 32'd1);
        chk("first_dbg_rdata", dbg_rdata, 32'h1000_0002);
        dbg_req = 1'b0;
        // CPU write then read
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        step();
        chk("wr_we_c1", {31'd0, mem_we}, 32'd1);
        chk("wr_addr_c1", mem_addr, 32'h10);
        chk("wr_data_c1", mem_wdata, 32'hDEAD_BEEF);
        chk("wr_stall_c1", {31'd0, cpu_stall}, 32'd1);
        step();
        chk("wr_we_c2", {31'd0, mem_we}, 32'd0);
        chk("wr_ack_c2", {31'd0, cpu_ack}, 32'd0);
        step();
        chk("wr_ack_c3", {31'd0, cpu_ack}, 32'd1);
        chk("wr_rdata_kept", cpu_rdata, 32'h1000_0001);
        cpu_we = 1'b0;
        step();
        chk("rd_ack_gone", {31'd0, cpu_ack}, 32'd0);
        chk("rd_no_grant_in_ack", {31'd0, mem_we}, 32'd0);
        step();
        chk("rd_issue_addr", mem_addr, 32'h10);
        chk("rd_issue_we", {31'd0, mem_we}, 32'd0);
        step();
        step();
        chk("rd_ack", {31'd0, cpu_ack}, 32'd1);
        chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
        cpu_req = 1'b0;
        step();
        // request held through its ack cycle gets one transaction only
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1111_1111;
        step();
        chk("dg_we_c1", {31'd0, mem_we}, 32'd1);
        step();
        step();
        chk("dg_ack", {31'd0, cpu_ack}, 32'd1);
        step();
        chk("dg_no_regrant", {31'd0, mem_we}, 32'd0);
        chk("dg_ack_off", {31'd0, cpu_ack}, 32'd0);
        cpu_req = 1'b0;
        step();
        chk("dg_idle_we", {31'd0, mem_we}, 32'd0);
        step();
        chk("dg_no_second_ack", {31'd0, cpu_ack}, 32'd0);
        // collision
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        step();
        chk("col_cpu_first", mem_addr, 32'h10);
        step();
        step();
        chk("col_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        chk("col_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("col_dbg_pending", {31'd0, dbg_ack}, 32'd0);
        cpu_req = 1'b0;
        step();
        chk("col_dbg_issue", mem_addr, 32'h20);
        step();
        step();
        chk("col_dbg_ack", {31'd0, dbg_ack}, 32'd1);
        chk("col_dbg_rdata", dbg_rdata, 32'h1111_1111);
        dbg_req = 1'b0;
        step();
        // starvation: debug contends in every CPU arbitration cycle
        cpu_req = 1'b1; cpu_addr = 32'h4; dbg_addr = 32'h8;
        for (int k = 0; k < 8; k++) begin
            dbg_req = 1'b1;
            step();
            chk($sformatf("stv_cpu_win%0d", k), mem_addr, 32'h4);
            dbg_req = 1'b0;
            step();
            step();
            chk($sformatf("stv_cpu_ack%0d", k), {31'd0, cpu_ack}, 32'd1);
            step();
        end
        dbg_req = 1'b1;
        step();
        chk("stv_dbg_win", mem_addr, 32'h8);
        step();
        step();
        chk("stv_dbg_ack", {31'd0, dbg_ack}, 32'd1);
        chk("stv_dbg_rdata", dbg_rdata, 32'h1000_0002);
        chk("stv_cpu_stalled", {31'd0, cpu_stall}, 32'd1);
        dbg_req = 1'b0;
        step();
        chk("stv_cpu_after", mem_addr, 32'h4);
        step();
        step();
        chk("stv_cpu_after_ack", {31'd0, cpu_ack}, 32'd1);
        step();
        dbg_req = 1'b1;
        step();
        chk("stv_cnt_cleared", mem_addr, 32'h4);
        step();
        step();
        cpu_req = 1'b0;
        step();
        chk("stv_dbg_next", mem_addr, 32'h8);
        step();
        step();
        chk("stv_dbg_next_ack", {31'd0, dbg_ack}, 32'd1);
        dbg_req = 1'b0;
        step();
        // reset during a CPU write issue
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hCAFE_F00D;
        step();
        chk("mr_we_issue", {31'd0, mem_we}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mr_we_async", {31'd0, mem_we}, 32'd0);
        chk("mr_addr_async", mem_addr, 32'd0);
        step();
        chk("mr_no_ack", {31'd0, cpu_ack}, 32'd0);
        resetn = 1'b1;
        step();
        chk("mr_restart_grant", {31'd0, mem_we}, 32'd1);
        chk("mr_restart_addr", mem_addr, 32'h30);
        step();
        chk("mr_restart_noack", {31'd0, cpu_ack}, 32'd0);
        step();
        chk("mr_restart_ack", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
